pcs_tx_frame_gen: RTL



---
 rtl/pcs_tx_frame_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pcs_tx_frame_gen.sv
// Synthetic Ethernet frame source for the PCS TX client interface (start/payload/term + IFG).
// Optional error injection (err_inj_i) is built when PCS_TX_FRAME_GEN_ERR_INJ_EN is defined.
module pcs_tx_frame_gen #(
  parameter int IS_10G      = 1,
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int LEN_W       = 11,
  parameter int IFG_W       = 4,
  localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic [IFG_W-1:0]       ifg_i,
`ifdef PCS_TX_FRAME_GEN_ERR_INJ_EN
  input  logic                   err_inj_i,
`endif
  input  logic                   ready_i,
  output logic                   ctrl_v_o,
  output logic                   idle_v_o,
  output logic [LANE0_CNT_N-1:0] start_v_o,
  output logic                   term_v_o,
  output logic                   err_v_o,
  output logic [KEEP_W-1:0]      keep_o,
  output logic [DATA_W-1:0]      data_o,
  output logic                   busy_o,
  output logic [15:0]            frame_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_GAP} state_t;

  localparam logic [DATA_W-1:0] IDLE_DATA  = {KEEP_W{8'h07}};
  localparam logic [DATA_W-1:0] START_DATA = {8'hD5, {(KEEP_W-1){8'h55}}};

  // r_state names the word currently on the outputs; w_* is the word registered next.
  state_t             r_state, w_state;
  logic [LEN_W-1:0]   r_rem, w_rem;
  logic [7:0]         r_byte, w_byte;
  logic [IFG_W-1:0]   r_gap, w_gap;
  logic [IFG_W-1:0]   r_ifg, w_ifg;
  logic [15:0]        r_frame_cnt, w_frame_cnt;
  logic               w_ctrl, w_idle, w_term, w_err, w_busy, w_payload, w_launch;
  logic [LANE0_CNT_N-1:0] w_start;
  logic [KEEP_W-1:0]  w_keep;
  logic [DATA_W-1:0]  w_data;
  logic [LEN_W-1:0]   w_len_eff;
  logic [IFG_W-1:0]   w_ifg_eff;

  assign w_len_eff = (len_i == '0) ? LEN_W'(1) : len_i;
  assign w_ifg_eff = (ifg_i == '0) ? IFG_W'(1) : ifg_i;

`ifdef PCS_TX_FRAME_GEN_ERR_INJ_EN
  logic r_err_flag;
  logic w_err_pend;
  assign w_err_pend = r_err_flag | err_inj_i;

  always_ff @(posedge clk) begin
    if (reset)
      r_err_flag <= 1'b0;
    else if (ready_i)
      r_err_flag <= w_err_pend & ~w_payload;
    else
      r_err_flag <= w_err_pend;
  end
`endif

  always_comb begin
    w_state     = r_state;
    w_rem       = r_rem;
    w_byte      = r_byte;
    w_gap       = r_gap;
    w_ifg       = r_ifg;
    w_frame_cnt = r_frame_cnt;
    w_ctrl      = 1'b1;
    w_idle      = 1'b1;
    w_start     = '0;
    w_term      = 1'b0;
    w_err       = 1'b0;
    w_keep      = '0;
    w_data      = IDLE_DATA;
    w_payload   = 1'b0;
    w_launch    = 1'b0;

    case (r_state)
      S_IDLE: w_launch = en_i;
      S_START, S_DATA: begin
        w_idle    = 1'b0;
        w_payload = 1'b1;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
          if (32'(r_rem) > i) begin
            w_keep[i]        = 1'b1;
            w_data[i*8 +: 8] = r_byte + 8'(i);
          end
        end
        // rem==KEEP_W yields a full DATA word, then rem==0 gives the empty TERM word.
        if (r_rem >= LEN_W'(KEEP_W)) begin
          w_ctrl  = 1'b0;
          w_state = S_DATA;
          w_rem   = r_rem - LEN_W'(KEEP_W);
          w_byte  = r_byte + 8'(KEEP_W);
        end else begin
          w_term      = 1'b1;
          w_state     = S_TERM;
          w_frame_cnt = r_frame_cnt + 16'd1;
        end
      end
      S_TERM: begin
        w_state = S_GAP;
        w_gap   = r_ifg;
      end
      S_GAP: begin
        if (r_gap > IFG_W'(1))
          w_gap = r_gap - IFG_W'(1);
        else if (en_i)
          w_launch = 1'b1;
        else
          w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_launch) begin
      w_state    = S_START;
      w_rem      = w_len_eff;
      w_byte     = '0;
      w_ifg      = w_ifg_eff;
      w_idle     = 1'b0;
      w_start[0] = 1'b1;
      w_data     = START_DATA;
    end

`ifdef PCS_TX_FRAME_GEN_ERR_INJ_EN
    if (w_payload && w_err_pend) begin
      w_err  = 1'b1;
      w_ctrl = 1'b1;
    end
`endif

    w_busy = (w_state == S_START) || (w_state == S_DATA) || (w_state == S_TERM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_byte      <= '0;
      r_gap       <= '0;
      r_ifg       <= '0;
      r_frame_cnt <= '0;
      ctrl_v_o    <= 1'b1;
      idle_v_o    <= 1'b1;
      start_v_o   <= '0;
      term_v_o    <= 1'b0;
      err_v_o     <= 1'b0;
      keep_o      <= '0;
      data_o      <= IDLE_DATA;
      busy_o      <= 1'b0;
    end else if (ready_i) begin
      r_state     <= w_state;
      r_rem       <= w_rem;
      r_byte      <= w_byte;
      r_gap       <= w_gap;
      r_ifg       <= w_ifg;
      r_frame_cnt <= w_frame_cnt;
      ctrl_v_o    <= w_ctrl;
      idle_v_o    <= w_idle;
      start_v_o   <= w_start;
      term_v_o    <= w_term;
      err_v_o     <= w_err;
      keep_o      <= w_keep;
      data_o      <= w_data;
      busy_o      <= w_busy;
    end
  end

  assign frame_cnt_o = r_frame_cnt;

endmodule
